// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Operands are reduced to magnitudes on accept. The unsigned core then runs
// shift-add multiply or restoring divide, and the FIX state restores the sign.
// Divide-by-zero and signed overflow bypass the core and finish after one cycle.
//
//   state | meaning
//   IDLE  | waiting for an M-extension op; accepts when valid_i && !flush_i
//   CALC  | BITS_PER_CYCLE multiply/divide steps per cycle, counter counts down to 1
//   FIX   | sign correction, result_o/rd_o registered
//   DONE  | valid_o high for one cycle, pipeline released
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1   // 1, 2 or 4; must divide XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_o;
  logic              r_valid;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_sh;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_fix;

  // Accept-time decode: signedness of each operand, magnitudes, result sign, special cases
  always_comb begin
    // MUL low half is sign-agnostic, so it runs unsigned
    w_a_sgn = a_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'd1 || op_i[1:0] == 2'd2));
    w_b_sgn = b_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'd1));
    w_a_mag = w_a_sgn ? -a_i : a_i;
    w_b_mag = w_b_sgn ? -b_i : b_i;
    // remainder follows the dividend; product and quotient follow sign difference
    w_neg   = (op_i[2] && op_i[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
    w_div0  = op_i[2] && (b_i == '0);
    w_ovf   = op_i[2] && !op_i[0] && (a_i == MIN_VAL) && (b_i == {XLEN{1'b1}});
    if (w_div0) w_spec_res = op_i[1] ? a_i : {XLEN{1'b1}};
    else        w_spec_res = op_i[1] ? '0 : MIN_VAL;
  end

  // One CALC cycle worth of unsigned steps; hi:lo is product or remainder:quotient
  always_comb begin
    w_hi  = r_hi;
    w_lo  = r_lo;
    w_sum = '0;
    w_sh  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_op[2]) begin
        w_sh = {w_hi, w_lo[XLEN-1]};
        w_lo = {w_lo[XLEN-2:0], 1'b0};
        if (w_sh >= {1'b0, r_b}) begin
          w_hi    = w_sh[XLEN-1:0] - r_b;
          w_lo[0] = 1'b1;
        end else begin
          w_hi = w_sh[XLEN-1:0];
        end
      end else begin
        w_sum = {1'b0, w_hi} + {1'b0, (w_lo[0] ? r_b : {XLEN{1'b0}})};
        w_hi  = w_sum[XLEN:1];
        w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
      end
    end
  end

  // Sign correction and result selection applied in FIX
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg ? -w_prod : w_prod;
    if (r_op[2])
      w_fix = r_op[1] ? (r_neg ? -r_hi : r_hi) : (r_neg ? -r_lo : r_lo);
    else
      w_fix = (r_op[1:0] == 2'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM with datapath registers and registered result beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_rd_o   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i && !flush_i) begin
            r_op  <= op_i;
            r_rd  <= rd_i;
            r_neg <= w_neg;
            r_hi  <= '0;
            r_lo  <= w_a_mag;
            r_b   <= w_b_mag;
            if (w_div0 || w_ovf) begin
              r_result <= w_spec_res;
              r_rd_o   <= rd_i;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt   <= CW'(ITER);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix;
            r_rd_o   <= r_rd;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        // the op in DONE is older than any redirect, so flush_i is ignored here
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle and the whole iteration; released in DONE
  always_comb begin
    stall_o = !rst && (((r_state == S_IDLE) && valid_i && !flush_i) ||
                       (r_state == S_CALC) || (r_state == S_FIX));
  end

  assign valid_o  = r_valid;
  assign result_o = r_result;
  assign rd_o     = r_rd_o;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. Two instances run side by side:
// one with one bit per cycle and one with four bits per cycle.
// The reference model computes results with 64-bit integer arithmetic.
module tb_ex_muldiv_unit;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        v = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;

  logic        v1, v4;
  logic        stall1, valid1, stall4, valid4;
  logic [31:0] res1, res4;
  logic [4:0]  rd1, rd4;
  logic        m_stall, m_valid;
  logic [31:0] m_result;
  logic [4:0]  m_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign v1       = v & ~sel;
  assign v4       = v & sel;
  assign m_stall  = sel ? stall4 : stall1;
  assign m_valid  = sel ? valid4 : valid1;
  assign m_result = sel ? res4 : res1;
  assign m_rd     = sel ? rd4 : rd1;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .valid_i(v1), .op_i(op), .a_i(a), .b_i(b), .rd_i(rd),
    .flush_i(flush), .stall_o(stall1), .valid_o(valid1), .result_o(res1), .rd_o(rd1));

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .valid_i(v4), .op_i(op), .a_i(a), .b_i(b), .rd_i(rd),
    .flush_i(flush), .stall_o(stall4), .valid_o(valid4), .result_o(res4), .rd_o(rd4));

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r  = '0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == MINV && y == 32'hFFFF_FFFF) r = MINV;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == MINV && y == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int iter);
    if (o >= 3'd4 && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == MINV && y == 32'hFFFF_FFFF)))
      return 1;
    return iter + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return MINV;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  // Waits from the accept cycle (cycle 0) to the result beat; lat stays -1 on timeout
  task automatic wait_result(output logic [31:0] res, output logic [4:0] rdo, output int lat, output int stalls);
    lat = -1; stalls = 0; res = '0; rdo = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_stall) stalls++;
      if (m_valid) begin
        lat = c; res = m_result; rdo = m_rd;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic run_op(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] d, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int stalls);
    @(posedge clk); #1;
    sel = s; op = o; a = x; b = y; rd = d; v = 1'b1;
    wait_result(res, rdo, lat, stalls);
    @(posedge clk); #1;
    v = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({valid1, stall1, res1, rd1, valid4, stall4, res4, rd4} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b s=%b r=%h d=%0d / v=%b s=%b r=%h d=%0d expected all zero",
               valid1, stall1, res1, rd1, valid4, stall4, res4, rd4);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({valid1, stall1, valid4, stall4} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 0000", {valid1, stall1, valid4, stall4});
    end
  endtask

  typedef struct { logic [2:0] o; logic [31:0] x; logic [31:0] y; logic [31:0] exp; } vec_t;

  task automatic test_directed(input logic s, input int iter);
    vec_t t[$];
    logic [31:0] res; logic [4:0] rdo; int lat, st, el;
    t.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    t.push_back('{3'd1, MINV, MINV, 32'h4000_0000});
    t.push_back('{3'd3, MINV, MINV, 32'h4000_0000});
    t.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
    t.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    t.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    t.push_back('{3'd5, 32'd100, 32'd7, 32'd14});
    t.push_back('{3'd7, 32'd100, 32'd7, 32'd2});
    t.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF});
    t.push_back('{3'd6, 32'd5, 32'd0, 32'd5});
    t.push_back('{3'd4, MINV, 32'hFFFF_FFFF, MINV});
    t.push_back('{3'd6, MINV, 32'hFFFF_FFFF, 32'd0});
    t.push_back('{3'd0, 32'h1234_5678, 32'd0, 32'd0});
    foreach (t[i]) begin
      el = exp_lat(t[i].o, t[i].x, t[i].y, iter);
      run_op(s, t[i].o, t[i].x, t[i].y, 5'(i + 1), res, rdo, lat, st);
      n_checks++;
      if (res !== t[i].exp || rdo !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL directed_result[%0d] bpc_sel=%0d op=%0d: got %h rd=%0d expected %h rd=%0d",
                 i, s, t[i].o, res, rdo, t[i].exp, i + 1);
      end
      n_checks++;
      if (lat !== el || st !== el) begin
        n_fail++;
        $display("FAIL directed_latency[%0d] bpc_sel=%0d: got lat=%0d stalls=%0d expected %0d/%0d",
                 i, s, lat, st, el, el);
      end
    end
  endtask

  task automatic test_random(input logic s, input int iter, input int n);
    logic [31:0] x, y, res, er; logic [2:0] o; logic [4:0] d, rdo; int lat, st, el;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom_range(0, 7)); x = pick(); y = pick(); d = 5'($urandom_range(0, 31));
      er = model(o, x, y);
      el = exp_lat(o, x, y, iter);
      run_op(s, o, x, y, d, res, rdo, lat, st);
      n_checks++;
      if (res !== er || rdo !== d) begin
        n_fail++;
        $display("FAIL random_result bpc_sel=%0d op=%0d a=%h b=%h: got %h rd=%0d expected %h rd=%0d",
                 s, o, x, y, res, rdo, er, d);
      end
      n_checks++;
      if (lat !== el || st !== el) begin
        n_fail++;
        $display("FAIL random_latency bpc_sel=%0d op=%0d: got lat=%0d stalls=%0d expected %0d",
                 s, o, lat, st, el);
      end
    end
  endtask

  task automatic test_flush_calc();
    logic [31:0] res; logic [4:0] rdo; int lat, st;
    @(posedge clk); #1;
    sel = 1'b0; op = 3'd4; a = 32'd100; b = 32'd7; rd = 5'd1; v = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; v = 1'b0;
    n_checks++;
    if (m_stall !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_calc_stall: got stall=%b valid=%b expected 0 0", m_stall, m_valid);
    end
    op = 3'd0; a = 32'd3; b = 32'd4; rd = 5'd2; v = 1'b1;
    wait_result(res, rdo, lat, st);
    @(posedge clk); #1;
    v = 1'b0;
    n_checks++;
    if (res !== 32'd12 || rdo !== 5'd2 || lat !== 34) begin
      n_fail++;
      $display("FAIL flush_calc_next_op: got %h rd=%0d lat=%0d expected 0000000c rd=2 lat=34", res, rdo, lat);
    end
  endtask

  task automatic test_flush_done();
    @(posedge clk); #1;
    sel = 1'b0; op = 3'd0; a = 32'd5; b = 32'd6; rd = 5'd3; v = 1'b1;
    repeat (34) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1 || m_result !== 32'd30 || m_rd !== 5'd3) begin
      n_fail++;
      $display("FAIL flush_in_done: got valid=%b %h rd=%0d expected 1 0000001e rd=3", m_valid, m_result, m_rd);
    end
    @(posedge clk); #1;
    flush = 1'b0; v = 1'b0;
  endtask

  task automatic test_flush_idle();
    int cnt;
    @(posedge clk); #1;
    sel = 1'b0; op = 3'd5; a = 32'd9; b = 32'd3; v = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_stall: got %b expected 0", m_stall);
    end
    repeat (3) @(posedge clk);
    #1 v = 1'b0; flush = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL flush_idle_accept: got %0d result beats expected 0", cnt);
    end
  endtask

  task automatic test_reset_mid(input logic s, input int iter);
    logic [31:0] res; logic [4:0] rdo; int lat, st;
    run_op(s, 3'd0, 32'd3, 32'd4, 5'd9, res, rdo, lat, st);
    n_checks++;
    if (res !== 32'd12) begin
      n_fail++;
      $display("FAIL pre_reset_op bpc_sel=%0d: got %h expected 0000000c", s, res);
    end
    @(posedge clk); #1;
    sel = s; op = 3'd4; a = 32'd1000; b = 32'd3; rd = 5'd5; v = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_valid, m_stall, m_result, m_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_calc bpc_sel=%0d: got v=%b s=%b r=%h d=%0d expected all zero",
               s, m_valid, m_stall, m_result, m_rd);
    end
    v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(s, 3'd5, 32'd1000, 32'd3, 5'd6, res, rdo, lat, st);
    n_checks++;
    if (res !== 32'd333 || rdo !== 5'd6 || lat !== iter + 2) begin
      n_fail++;
      $display("FAIL post_reset_op bpc_sel=%0d: got %h rd=%0d lat=%0d expected 0000014d rd=6 lat=%0d",
               s, res, rdo, lat, iter + 2);
    end
  endtask

  initial begin
    test_reset();
    test_directed(1'b0, 32);
    test_directed(1'b1, 8);
    test_random(1'b0, 32, 40);
    test_random(1'b1, 8, 60);
    test_flush_calc();
    test_flush_done();
    test_flush_idle();
    test_reset_mid(1'b0, 32);
    test_reset_mid(1'b1, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
